// File: rtl/sc_udatapath_ctrl.sv
// Micro-datapath controller and ALU stage around the general-register bank.
// Define UDP_CTRL_CMP_ONLY_EN to add Instr_NoWrite (flags-only, no write-back).
//
// state | meaning
// IDLE  | ready for an instruction; Done pulses here after a completed instruction
// FETCH | source registers drive bus A / bus B for one cycle
// EXEC  | operands held; result and flags registered at the next edge
// WRITE | result on DataBUS_Out, destination write strobe high for one cycle
module sc_udatapath_ctrl #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int REGNUM        = 8,
  parameter int REGSEL_WIDTH  = 3
) (
  input  logic                     CLOCK_50,
  input  logic                     SC_RegGENERAL_Reset_InHigh,
  input  logic                     Instr_Valid,
  output logic                     Instr_Ready,
  input  logic [REGSEL_WIDTH-1:0]  Instr_SrcA,
  input  logic [REGSEL_WIDTH-1:0]  Instr_SrcB,
  input  logic [REGSEL_WIDTH-1:0]  Instr_Dst,
  input  logic [2:0]               Instr_Op,
`ifdef UDP_CTRL_CMP_ONLY_EN
  input  logic                     Instr_NoWrite,
`endif
  input  logic [DATAWIDTH_BUS-1:0] DataBUS_A_In,
  input  logic [DATAWIDTH_BUS-1:0] DataBUS_B_In,
  output logic [REGNUM-1:0]        Enable_BUS_A_Out,
  output logic [REGNUM-1:0]        Enable_BUS_B_Out,
  output logic [REGNUM-1:0]        Write_InHigh_Out,
  output logic [DATAWIDTH_BUS-1:0] DataBUS_Out,
  output logic [3:0]               Flags_Out,
  output logic                     Done_Out
);

  localparam int W = DATAWIDTH_BUS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [1:0]              r_state;
  logic [REGSEL_WIDTH-1:0] r_dst;
  logic [2:0]              r_op;
  logic [W-1:0]            r_op_a;
  logic [W-1:0]            r_op_b;
  logic [REGNUM-1:0]       r_en_a;
  logic [REGNUM-1:0]       r_en_b;
  logic [REGNUM-1:0]       r_wr;
  logic [W-1:0]            r_data_out;
  logic [3:0]              r_flags;
  logic                    r_done;
  logic                    w_nowrite;

  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic [3:0]   w_flags;

`ifdef UDP_CTRL_CMP_ONLY_EN
  logic r_nowrite;
  assign w_nowrite = r_nowrite;
`else
  assign w_nowrite = 1'b0;
`endif

  // Out-of-range indices decode to no bit at all, so no register is touched.
  function automatic logic [REGNUM-1:0] f_onehot(input logic [REGSEL_WIDTH-1:0] idx);
    logic [REGNUM-1:0] v;
    v = '0;
    for (int i = 0; i < REGNUM; i++) begin
      if (idx == REGSEL_WIDTH'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Subtract as A + ~B + 1 so the carry-out is directly the no-borrow flag.
  assign w_sum  = {1'b0, r_op_a} + {1'b0, r_op_b};
  assign w_diff = {1'b0, r_op_a} + {1'b0, ~r_op_b} + {{W{1'b0}}, 1'b1};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[W-1] != r_op_a[W-1]);
      end
      OP_SUB: begin
        w_res = w_diff[W-1:0];
        w_c   = w_diff[W];
        w_v   = (r_op_a[W-1] != r_op_b[W-1]) && (w_diff[W-1] != r_op_a[W-1]);
      end
      OP_AND: w_res = r_op_a & r_op_b;
      OP_OR:  w_res = r_op_a | r_op_b;
      OP_XOR: w_res = r_op_a ^ r_op_b;
      OP_NOT: w_res = ~r_op_a;
      OP_SHL: begin
        w_res = {r_op_a[W-2:0], 1'b0};
        w_c   = r_op_a[W-1];
      end
      OP_SHR: begin
        w_res = {1'b0, r_op_a[W-1:1]};
        w_c   = r_op_a[0];
      end
      default: ;
    endcase
  end

  assign w_flags = {w_res[W-1], (w_res == '0), w_c, w_v};

  // Strobes default low every cycle, so each is exactly one cycle wide.
  always_ff @(posedge CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      r_state    <= ST_IDLE;
      r_dst      <= '0;
      r_op       <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_en_a     <= '0;
      r_en_b     <= '0;
      r_wr       <= '0;
      r_data_out <= '0;
      r_flags    <= '0;
      r_done     <= 1'b0;
`ifdef UDP_CTRL_CMP_ONLY_EN
      r_nowrite  <= 1'b0;
`endif
    end else begin
      r_en_a <= '0;
      r_en_b <= '0;
      r_wr   <= '0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Instr_Valid) begin
            r_dst     <= Instr_Dst;
            r_op      <= Instr_Op;
            r_en_a    <= f_onehot(Instr_SrcA);
            r_en_b    <= f_onehot(Instr_SrcB);
`ifdef UDP_CTRL_CMP_ONLY_EN
            r_nowrite <= Instr_NoWrite;
`endif
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_op_a  <= DataBUS_A_In;
          r_op_b  <= DataBUS_B_In;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_flags <= w_flags;
          if (w_nowrite) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_data_out <= w_res;
            r_wr       <= f_onehot(r_dst);
            r_state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Instr_Ready      = (r_state == ST_IDLE);
  assign Enable_BUS_A_Out = r_en_a;
  assign Enable_BUS_B_Out = r_en_b;
  assign Write_InHigh_Out = r_wr;
  assign DataBUS_Out      = r_data_out;
  assign Flags_Out        = r_flags;
  assign Done_Out         = r_done;

endmodule

// File: tb/tb_sc_udatapath_ctrl.sv
// Self-checking bench for sc_udatapath_ctrl: behavioural instruction model,
// emulated register bank on the operand buses, directed and random stimulus.
module tb_sc_udatapath_ctrl;
  localparam int W    = 32;
  localparam int RN   = 6;
  localparam int RS   = 3;
  localparam int MAXC = 4096;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [RS-1:0] src_a = '0, src_b = '0, dst = '0;
  logic [2:0]    op = '0;
  logic          nowrite = 1'b0;
  logic [W-1:0]  bus_a, bus_b;
  logic          ready, done;
  logic [RN-1:0] en_a, en_b, wr;
  logic [W-1:0]  dout;
  logic [3:0]    flags;

  sc_udatapath_ctrl #(.DATAWIDTH_BUS(W), .REGNUM(RN), .REGSEL_WIDTH(RS)) dut (
    .CLOCK_50(clk),
    .SC_RegGENERAL_Reset_InHigh(rst),
    .Instr_Valid(valid),
    .Instr_Ready(ready),
    .Instr_SrcA(src_a),
    .Instr_SrcB(src_b),
    .Instr_Dst(dst),
    .Instr_Op(op),
`ifdef UDP_CTRL_CMP_ONLY_EN
    .Instr_NoWrite(nowrite),
`endif
    .DataBUS_A_In(bus_a),
    .DataBUS_B_In(bus_b),
    .Enable_BUS_A_Out(en_a),
    .Enable_BUS_B_Out(en_b),
    .Write_InHigh_Out(wr),
    .DataBUS_Out(dout),
    .Flags_Out(flags),
    .Done_Out(done)
  );

  // Register bank emulation: capture on negedge, drive buses when enabled.
  logic [W-1:0] env_regs [RN] = '{32'd3, 32'd5, 32'd7, 32'd0, 32'h10, 32'h7FFFFFFF};
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < RN; i++) if (wr[i]) env_regs[i] = dout;
  end
  always_comb begin
    bus_a = '0;
    bus_b = '0;
    for (int i = 0; i < RN; i++) begin
      if (en_a[i]) bus_a = env_regs[i];
      if (en_b[i]) bus_b = env_regs[i];
    end
  end

  int n_chk = 0, n_err = 0;
  int cyc = -1, nf = -1;
  bit run = 1'b0, m_acc = 1'b0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic m_alu(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [3:0] f);
    longint ua, ub, sa, sb, t;
    bit c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; r = '0;
    case (o)
      3'd0: begin t = ua + ub; r = W'(t); c = (t > UMAX); v = (sa + sb > SMAX) || (sa + sb < SMIN); end
      3'd1: begin t = ua - ub; r = W'(t); c = (ua >= ub); v = (sa - sb > SMAX) || (sa - sb < SMIN); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = W'(ua * 2); c = (ua > SMAX); end
      default: begin r = W'(ua / 2); c = (ua % 2 == 1); end
    endcase
    f = {r[W-1], (r == '0), c, v};
  endtask

  function automatic logic [RN-1:0] oh(input logic [RS-1:0] idx);
    return (int'(idx) < RN) ? (RN'(1) << idx) : '0;
  endfunction

  // Expected outputs per cycle, filled in when the model accepts an instruction.
  logic [RN-1:0] e_ena [MAXC], e_enb [MAXC], e_wr [MAXC];
  bit            e_done [MAXC];
  bit            d_set [MAXC], d_kn [MAXC], f_set [MAXC], f_kn [MAXC];
  logic [W-1:0]  d_val [MAXC];
  logic [3:0]    f_val [MAXC];
  logic [W-1:0]  m_regs [RN] = '{32'd3, 32'd5, 32'd7, 32'd0, 32'h10, 32'h7FFFFFFF};

  initial forever begin
    @(posedge clk);
    if (run) begin
      cyc++;
      m_acc = 1'b0;
      if (valid && (cyc - 1 >= nf)) begin
        logic [W-1:0] a, b, r;
        logic [3:0]   f;
        bit           kn;
        m_acc = 1'b1;
        e_ena[cyc] = oh(src_a);
        e_enb[cyc] = oh(src_b);
        kn = (int'(src_a) < RN) && (int'(src_b) < RN);
        a = '0; b = '0;
        if (kn) begin a = m_regs[src_a]; b = m_regs[src_b]; end
        m_alu(op, a, b, r, f);
        f_set[cyc+2] = 1'b1; f_val[cyc+2] = f; f_kn[cyc+2] = kn;
        if (nowrite) begin
          e_done[cyc+2] = 1'b1;
          nf = cyc + 2;
        end else begin
          e_wr[cyc+2] = oh(dst);
          d_set[cyc+2] = 1'b1; d_val[cyc+2] = r; d_kn[cyc+2] = kn;
          if (int'(dst) < RN) m_regs[dst] = r;
          e_done[cyc+3] = 1'b1;
          nf = cyc + 3;
        end
      end
    end
  end

  logic [W-1:0] cur_d = '0;
  logic [3:0]   cur_f = '0;
  bit           cur_dk = 1'b1, cur_fk = 1'b1;
  logic [W-1:0] dq_d [$];
  logic [3:0]   dq_f [$];

  initial forever begin
    @(negedge clk);
    if (run && cyc >= 0) begin
      if (d_set[cyc]) begin cur_d = d_val[cyc]; cur_dk = d_kn[cyc]; end
      if (f_set[cyc]) begin cur_f = f_val[cyc]; cur_fk = f_kn[cyc]; end
      check("ready", ready, cyc >= nf);
      check("en_a", en_a, e_ena[cyc]);
      check("en_b", en_b, e_enb[cyc]);
      check("write", wr, e_wr[cyc]);
      check("done", done, e_done[cyc]);
      if (cur_dk) check("data", dout, cur_d);
      if (cur_fk) check("flags", flags, cur_f);
      check("en_wr_overlap", ((|en_a || |en_b) && |wr), 0);
      if (done) begin dq_d.push_back(dout); dq_f.push_back(flags); end
    end
  end

  task automatic issue(input logic [2:0] o, input int a, input int b, input int d, input bit nw);
    valid = 1'b1; op = o; src_a = RS'(a); src_b = RS'(b); dst = RS'(d); nowrite = nw;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (m_acc) break;
    end
    if (!m_acc) begin
      n_chk++; n_err++;
      $display("FAIL accept_timeout got=no_accept expected=accept");
    end
    valid = 1'b0;
  endtask

  logic [W-1:0] pr, saved;
  logic [3:0]   pf;
  logic [W-1:0] lit_d [8];
  logic [3:0]   lit_f [8];

  initial begin
    m_alu(3'd0, 32'd5, 32'd7, pr, pf);                 check("pin_add", pr, 32'd12);  check("pin_add_f", pf, 4'b0000);
    m_alu(3'd1, 32'd3, 32'd5, pr, pf);                 check("pin_sub", pr, 32'hFFFFFFFE); check("pin_sub_f", pf, 4'b1000);
    m_alu(3'd0, 32'h7FFFFFFF, 32'd1, pr, pf);          check("pin_ovf", pr, 32'h80000000); check("pin_ovf_f", pf, 4'b1001);
    m_alu(3'd1, 32'd9, 32'd9, pr, pf);                 check("pin_cmp", pr, 32'd0);   check("pin_cmp_f", pf, 4'b0110);
    m_alu(3'd7, 32'd1, 32'd0, pr, pf);                 check("pin_shr", pr, 32'd0);   check("pin_shr_f", pf, 4'b0110);

    valid = 1'b1; src_a = 3'd1; src_b = 3'd2; dst = 3'd3; op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_en_a", en_a, '0);
    check("rst_en_b", en_b, '0);
    check("rst_write", wr, '0);
    check("rst_flags", flags, '0);
    check("rst_data", dout, '0);
    check("rst_done", done, 1'b0);
    valid = 1'b0; rst = 1'b0; run = 1'b1;

    issue(3'd0, 1, 2, 3, 0);
    issue(3'd1, 0, 1, 3, 0);
    issue(3'd5, 3, 0, 0, 0);
    issue(3'd0, 5, 0, 2, 0);
    issue(3'd3, 3, 0, 3, 0);
    issue(3'd0, 3, 0, 1, 0);
    issue(3'd7, 0, 0, 1, 0);
    issue(3'd6, 4, 4, 4, 0);
    repeat (5) begin @(posedge clk); #1; end

    lit_d = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 32'h20};
    lit_f = '{4'b0000, 4'b1000, 4'b0000, 4'b1001, 4'b1000, 4'b0110, 4'b0110, 4'b0000};
    check("lit_done_count", dq_d.size(), 8);
    for (int i = 0; i < 8 && i < dq_d.size(); i++) begin
      check($sformatf("lit_data%0d", i), dq_d[i], lit_d[i]);
      check($sformatf("lit_flags%0d", i), dq_f[i], lit_f[i]);
    end
    check("lit_r0", env_regs[0], 32'd1);
    check("lit_r1", env_regs[1], 32'd0);
    check("lit_r2", env_regs[2], 32'h80000000);
    check("lit_r3", env_regs[3], 32'hFFFFFFFF);
    check("lit_r4", env_regs[4], 32'h20);

    issue(3'd0, 0, 1, 6, 0);
    issue(3'd0, 7, 1, 7, 0);
    issue(3'd2, 1, 6, 6, 0);
`ifdef UDP_CTRL_CMP_ONLY_EN
    issue(3'd1, 3, 3, 2, 1);
    repeat (4) begin @(posedge clk); #1; end
    check("cmp_flags", flags, 4'b0110);
    check("cmp_no_write_r2", env_regs[2], 32'h80000000);
`endif

    for (int n = 0; n < 300; n++) begin
      int a, b, d, sel;
      bit nw;
      a = int'($urandom_range(0, RN - 1));
      b = int'($urandom_range(0, RN - 1));
      d = int'($urandom_range(0, RN - 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin a = int'($urandom_range(RN, 7)); d = int'($urandom_range(RN, 7)); end
      else if (sel == 1) begin b = int'($urandom_range(RN, 7)); d = int'($urandom_range(RN, 7)); end
      else if (sel == 2) d = int'($urandom_range(RN, 7));
      nw = 1'b0;
`ifdef UDP_CTRL_CMP_ONLY_EN
      nw = ($urandom_range(0, 3) == 0);
`endif
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(3'($urandom_range(0, 7)), a, b, d, nw);
    end
    for (int k = 0; k < 20 && cyc < nf + 2; k++) begin @(posedge clk); #1; end
    run = 1'b0;

    saved = env_regs[5];
    valid = 1'b1; op = 3'd0; src_a = 3'd1; src_b = 3'd2; dst = 3'd5; nowrite = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    check("mr_fetch_en_a", en_a, 6'h02);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mr_write_at_assert", wr, '0);
    check("mr_ready_at_assert", ready, 1'b1);
    check("mr_en_at_assert", en_a | en_b, '0);
    @(posedge clk); #1;
    check("mr_write_in_reset", wr, '0);
    rst = 1'b0;
    @(negedge clk);
    check("mr_ready_after", ready, 1'b1);
    check("mr_write_after", wr, '0);
    check("mr_done_after", done, 1'b0);
    @(posedge clk); #1;
    check("mr_write_later", wr, '0);
    @(negedge clk);
    check("mr_r5_kept", env_regs[5], saved);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sc_udatapath_ctrl.md
Name: sc_udatapath_ctrl

Overview:
- Micro-datapath controller and ALU stage that sits around the general-register bank.
- Drives the per-register bus-A/bus-B output enables and write strobes, and samples the two tri-stated operand buses.
- Computes one ALU operation per accepted instruction and drives the result onto the shared register input bus.
- Multi-cycle FSM with a valid/ready instruction handshake.

Parameters:
- DATAWIDTH_BUS, 32, width of operand buses, result bus and ALU.
- REGNUM, 8, number of general registers; width of the one-hot enable/write vectors.
- REGSEL_WIDTH, 3, width of register index fields; REGNUM <= 2**REGSEL_WIDTH.

Ports:
- CLOCK_50  in  1  controller clock; FSM and all outputs update on posedge.
- SC_RegGENERAL_Reset_InHigh  in  1  reset, asynchronous, active-high.
- Instr_Valid  in  1  instruction offered.
- Instr_Ready  out  1  controller can accept an instruction.
- Instr_SrcA  in  REGSEL_WIDTH  register driven onto bus A.
- Instr_SrcB  in  REGSEL_WIDTH  register driven onto bus B.
- Instr_Dst  in  REGSEL_WIDTH  destination register.
- Instr_Op  in  3  ALU opcode.
- DataBUS_A_In  in  DATAWIDTH_BUS  shared tri-state bus A.
- DataBUS_B_In  in  DATAWIDTH_BUS  shared tri-state bus B.
- Enable_BUS_A_Out  out  REGNUM  one-hot bus-A enables.
- Enable_BUS_B_Out  out  REGNUM  one-hot bus-B enables.
- Write_InHigh_Out  out  REGNUM  one-hot register write strobes.
- DataBUS_Out  out  DATAWIDTH_BUS  result bus to every register input.
- Flags_Out  out  4  {N, Z, C, V}, registered.
- Done_Out  out  1  one-cycle pulse, write-back complete.

Behaviour:
- Registers capture on negedge; controller updates on posedge. Each strobe is therefore stable for the whole capturing negedge.
- Reset (async): FSM to IDLE. Instr_Ready=1. Enables, writes, Done, Flags, DataBUS_Out, operand/result latches all 0.
- States: IDLE -> FETCH -> EXEC -> WRITE -> IDLE.
- IDLE:
  - Instr_Ready=1.
  - On Valid&&Ready at posedge: latch SrcA, SrcB, Dst, Op; go to FETCH.
  - Valid while not in IDLE is ignored (Ready=0). The instruction must be held until accepted.
- FETCH:
  - Enable_A=1<<SrcA, Enable_B=1<<SrcB, for exactly one cycle.
  - OpA/OpB sampled from the buses at the next posedge.
  - SrcA==SrcB is legal: the same register drives both buses.
- EXEC:
  - Enables return to 0.
  - Result and flags computed from OpA/OpB, registered at the next posedge.
- WRITE:
  - DataBUS_Out=result and Write=1<<Dst, for exactly one cycle.
  - Done_Out=1 in the cycle after WRITE (the IDLE cycle); Ready=1 in that same cycle.
- Latency: accept at posedge t; enables active t..t+1; write active t+2..t+3; Done high t+3..t+4.
- Throughput: one instruction per 4 cycles. Back-to-back: a new accept is allowed in the Done cycle.
- Dst equal to SrcA/SrcB: operands are already latched, so the result is correct.
- DataBUS_Out holds its last value outside WRITE. It is never tri-stated.
- Ops (W=DATAWIDTH_BUS, all results mod 2^W):
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL1 A
  - 111 SHR1 A (logical)
- Flags:
  - N = result[W-1]. Z = (result==0).
  - C: ADD carry-out; SUB no-borrow (A>=B unsigned); SHL bit shifted out; SHR bit 0 shifted out; 0 for logic ops.
  - V: signed overflow for ADD/SUB; 0 otherwise.
- Index >= REGNUM: no enable or write bit set. The bus then floats, the sampled operand is X, and no write occurs. This is a tested illegal case: strobes must stay 0.
- Reset mid-operation: immediate abort. No write strobe may occur after reset assertion. The instruction is lost.

Optional Feature:
- Macro UDP_CTRL_CMP_ONLY_EN.
- Defined:
  - Extra input Instr_NoWrite (1 bit), latched at accept.
  - When 1, EXEC goes directly to IDLE: flags update, no write strobe, DataBUS_Out unchanged.
  - Done pulses in the cycle after EXEC, giving 3-cycle latency.
- Undefined: port absent; every instruction writes back.

Test Plan:
- Reset with Valid=1 -> Ready=1, all enables/writes/Flags=0. Release reset, R1=5, R2=7, ADD dst R3 -> Enable_A=0x02, Enable_B=0x04 for 1 cycle; Write=0x08 with DataBUS_Out=12; Done 3 cycles after accept; Flags=0000.
- SUB R1=3 minus R2=5 -> result 0xFFFFFFFE, N=1, Z=0, C=0, V=0. ADD 0x7FFFFFFF+1 -> 0x80000000, V=1, N=1.
- ADD 0xFFFFFFFF+1 -> result 0, Z=1, C=1. SHR1 of 0x00000001 -> 0, C=1, Z=1.
- Dst=SrcA=R4 (R4=0x10), SHL1 -> R4 becomes 0x20. Back-to-back second instruction accepted in the Done cycle -> no overlap of enable and write strobes.
- Reset asserted during EXEC -> Write_InHigh_Out stays 0, FSM in IDLE, Ready=1 next cycle.
- UDP_CTRL_CMP_ONLY_EN defined, NoWrite=1, SUB 9-9 -> Z=1, no write strobe, Done at accept+2.
